// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory stage: funct3 size/sign codes, FSM states,
// and the lane/legality helpers used when a request is issued.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] encodes the access size for every legal load and store code.
    function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic code_ok;
        logic aligned;
        if (is_store) code_ok = f3 inside {F3_B, F3_H, F3_W};
        else          code_ok = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        case (f3[1:0])
            2'b01:   aligned = ~lo[0];
            2'b10:   aligned = (lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return code_ok && aligned;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data bus between the memory stage (master) and memory (slave).
interface mem_access_unit_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBE;
    logic [31:0] MemRData;
    logic        MemAck;

    modport master (output MemReq, MemWe, MemAddr, MemWData, MemBE,
                    input  MemRData, MemAck);
    modport slave  (input  MemReq, MemWe, MemAddr, MemWData, MemBE,
                    output MemRData, MemAck);
endinterface

// File: rtl/load_formatter.sv
// Combinational load-data formatter: picks the byte/half addressed by addr_lo
// and sign- or zero-extends it according to funct3.
module load_formatter
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result = {24'b0, byte_sel};
            F3_HU:   result = {16'b0, half_sel};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage bus master: turns a load/store in M into one req/ack transaction,
// stalls the pipeline while it is outstanding, and formats load data for WB.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    mem_access_unit_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_inc;
    logic [2:0]    funct3_q;
    logic [1:0]    addr_lo_q;
    logic [31:0]   load_result;
    logic          access, legal, start, ack_done, timeout;

    assign access  = MemReadM | MemWriteM;
    assign legal   = access_legal(MemWriteM, Funct3M, ALUResultM[1:0]);
    assign cnt_inc = cnt_q + 1'b1;

    load_formatter u_load_formatter (
        .rdata   (bus.MemRData),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .result  (load_result)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        start     = 1'b0;
        ack_done  = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && legal) begin
                    start   = 1'b1;
                    StallM  = 1'b1;
                    state_d = REQ;
                end else if (access) begin
                    MisalignM = 1'b1;
                end
            end
            REQ: begin
                StallM = 1'b1;
                if (bus.MemAck) begin
                    ack_done = 1'b1;
                    state_d  = DONE;
                end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.MemReq   <= 1'b0;
            bus.MemWe    <= 1'b0;
            bus.MemAddr  <= '0;
            bus.MemWData <= '0;
            bus.MemBE    <= '0;
            ReadDataM    <= '0;
            BusErrM      <= 1'b0;
            cnt_q        <= '0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
        end else begin
            if (start) begin
                bus.MemReq   <= 1'b1;
                bus.MemWe    <= MemWriteM;
                bus.MemAddr  <= {ALUResultM[31:2], 2'b00};
                bus.MemBE    <= lane_be(Funct3M[1:0], ALUResultM[1:0]);
                bus.MemWData <= lane_wdata(Funct3M[1:0], WriteDataM);
                funct3_q     <= Funct3M;
                addr_lo_q    <= ALUResultM[1:0];
                cnt_q        <= '0;
            end
            if (MisalignM) ReadDataM <= '0;
            if (ack_done) begin
                bus.MemReq <= 1'b0;
                if (!bus.MemWe) ReadDataM <= load_result;
            end else if (timeout) begin
                bus.MemReq <= 1'b0;
                ReadDataM  <= '0;
                BusErrM    <= 1'b1;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_inc;
            end
            if (state_q == DONE) BusErrM <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level reference model,
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_mem_access_unit;
    localparam int T = 16;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs for the current cycle, set by the driver.
    logic        chk_en = 1'b0;
    logic        exp_stall = 0, exp_mis = 0, exp_berr = 0, exp_req = 0, exp_we = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0, exp_rdata = 0;
    logic [3:0]  exp_be = 0;
    logic [31:0] rd_model = 0;

    // Cumulative observations used by the directed literal checks.
    int          stall_total = 0, mis_total = 0, berr_total = 0, req_total = 0;
    logic [3:0]  seen_be = 0;
    logic [31:0] seen_wdata = 0, seen_addr = 0;
    logic        seen_we = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("StallM", {31'b0, StallM}, {31'b0, exp_stall});
            check("MisalignM", {31'b0, MisalignM}, {31'b0, exp_mis});
            check("BusErrM", {31'b0, BusErrM}, {31'b0, exp_berr});
            check("MemReq", {31'b0, bus.MemReq}, {31'b0, exp_req});
            check("ReadDataM", ReadDataM, exp_rdata);
            if (exp_req) begin
                check("MemAddr", bus.MemAddr, exp_addr);
                check("MemWe", {31'b0, bus.MemWe}, {31'b0, exp_we});
                if (exp_we) begin
                    check("MemBE", {28'b0, bus.MemBE}, {28'b0, exp_be});
                    check("MemWData", bus.MemWData, exp_wdata);
                end
            end
        end
        if (StallM)    stall_total++;
        if (MisalignM) mis_total++;
        if (BusErrM)   berr_total++;
        if (bus.MemReq) begin
            req_total++;
            seen_be    = bus.MemBE;
            seen_wdata = bus.MemWData;
            seen_addr  = bus.MemAddr;
            seen_we    = bus.MemWe;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic model_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        nbytes = 1 << f3[1:0];
        return (a % nbytes) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'd0:    return (wd & 32'hFF) * 32'h01010101;
            2'd1:    return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> (8 * (a % 4));
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd4:    return sh & 32'hFF;
            3'd5:    return sh & 32'hFFFF;
            default: return rdata;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One M-stage instruction; waits >= T means the slave never acknowledges.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdata, input int waits);
        logic ok, timed_out;
        int   nreq;
        ok = model_legal(wr, f3, a);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
        bus.MemAck   = 1'($urandom_range(0, 1));
        bus.MemRData = $urandom;
        exp_stall = ok; exp_mis = !ok; exp_req = 1'b0; exp_berr = 1'b0;
        step();
        if (!ok) begin
            rd_model = '0;
            exp_rdata = rd_model;
            MemReadM = 1'b0; MemWriteM = 1'b0;
            exp_mis = 1'b0; exp_stall = 1'b0;
            bus.MemAck = 1'b0;
            step();
            return;
        end
        nreq = (waits < T) ? waits + 1 : T;
        exp_req   = 1'b1;
        exp_we    = wr;
        exp_addr  = a & ~32'h3;
        exp_be    = model_be(f3, a);
        exp_wdata = model_wdata(f3, wd);
        for (int k = 0; k < nreq; k++) begin
            exp_stall    = 1'b1;
            bus.MemAck   = (k == waits);
            bus.MemRData = (k == waits) ? rdata : $urandom;
            step();
        end
        timed_out = (waits >= T);
        if (timed_out)  rd_model = '0;
        else if (!wr)   rd_model = model_load(f3, a, rdata);
        exp_rdata = rd_model;
        exp_stall = 1'b0; exp_req = 1'b0; exp_berr = timed_out;
        bus.MemAck   = 1'($urandom_range(0, 1));
        bus.MemRData = $urandom;
        step();
        MemReadM = 1'b0; MemWriteM = 1'b0;
        exp_berr = 1'b0;
        bus.MemAck = 1'($urandom_range(0, 1));
        step();
        bus.MemAck = 1'b0;
    endtask

    int s0, m0, b0, r0;

    task automatic snap();
        s0 = stall_total; m0 = mis_total; b0 = berr_total; r0 = req_total;
    endtask

    initial begin
        reset = 1'b1;
        MemReadM = 0; MemWriteM = 0; Funct3M = 0; ALUResultM = 0; WriteDataM = 0;
        bus.MemAck = 0; bus.MemRData = 0;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_StallM", {31'b0, StallM}, 32'd0);
        check("reset_MemReq", {31'b0, bus.MemReq}, 32'd0);
        check("reset_ReadDataM", ReadDataM, 32'd0);
        check("reset_MemBE", {28'b0, bus.MemBE}, 32'd0);
        @(posedge clk); #1;
        chk_en = 1'b1;

        snap(); do_access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
        check("lw_stall_cycles", stall_total - s0, 2);
        check("lw_data", ReadDataM, 32'hDEADBEEF);

        do_access(1, 0, 3'b000, 32'h103, 0, 32'h80FFFF7F, 0);
        check("lb_data", ReadDataM, 32'hFFFFFF80);
        do_access(1, 0, 3'b100, 32'h103, 0, 32'h80FFFF7F, 1);
        check("lbu_data", ReadDataM, 32'h00000080);
        do_access(1, 0, 3'b001, 32'h102, 0, 32'h80FFFF7F, 2);
        check("lh_data", ReadDataM, 32'hFFFF80FF);

        snap(); do_access(1, 0, 3'b010, 32'h104, 0, 32'h12345678, T);
        check("timeout_berr_pulses", berr_total - b0, 1);
        check("timeout_stall_cycles", stall_total - s0, T + 1);
        check("timeout_data", ReadDataM, 32'h0);

        do_access(0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 0);
        check("sb_be", {28'b0, seen_be}, 32'h2);
        check("sb_wdata", seen_wdata, 32'hABABABAB);
        check("sb_we", {31'b0, seen_we}, 32'h1);
        check("sb_addr", seen_addr, 32'h200);
        do_access(0, 1, 3'b001, 32'h202, 32'h0000CDEF, 0, 0);
        check("sh_be", {28'b0, seen_be}, 32'hC);

        do_access(1, 0, 3'b010, 32'h108, 0, 32'h55AA55AA, 0);
        snap(); do_access(1, 0, 3'b010, 32'h102, 0, 0, 0);
        check("misalign_pulses", mis_total - m0, 1);
        check("misalign_no_req", req_total - r0, 0);
        check("misalign_no_stall", stall_total - s0, 0);
        check("misalign_data", ReadDataM, 32'h0);

        snap(); do_access(1, 0, 3'b010, 32'h10C, 0, 32'h0BADF00D, 3);
        check("wait3_stall_cycles", stall_total - s0, 5);
        snap(); do_access(1, 0, 3'b010, 32'h110, 0, 32'hCAFEF00D, T - 1);
        check("late_ack_no_err", berr_total - b0, 0);
        check("late_ack_data", ReadDataM, 32'hCAFEF00D);

        // Reset during the second REQ cycle aborts the access.
        chk_en = 1'b0;
        MemReadM = 1; Funct3M = 3'b010; ALUResultM = 32'h300;
        step(); step();
        reset = 1'b1; MemReadM = 0;
        step();
        reset = 1'b0; bus.MemAck = 1'b1; bus.MemRData = 32'hFFFFFFFF;
        @(negedge clk);
        check("rst_req_MemReq", {31'b0, bus.MemReq}, 32'd0);
        check("rst_req_StallM", {31'b0, StallM}, 32'd0);
        @(posedge clk); #1;
        bus.MemAck = 1'b0;
        @(negedge clk);
        check("stale_ack_MemReq", {31'b0, bus.MemReq}, 32'd0);
        check("stale_ack_ReadDataM", ReadDataM, 32'd0);
        check("stale_ack_BusErrM", {31'b0, BusErrM}, 32'd0);
        @(posedge clk); #1;
        rd_model = '0; exp_rdata = '0;
        exp_stall = 0; exp_mis = 0; exp_berr = 0; exp_req = 0;
        chk_en = 1'b1;

        for (int i = 0; i < 300; i++) begin
            int          kind, waits;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 7) f3 = 3'($urandom_range(0, 2));
            else                          f3 = 3'($urandom_range(0, 7));
            if (kind == 0 && $urandom_range(0, 1) == 1 && f3 != 3'd2) f3 = f3 | 3'b100;
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       waits = T - 1;
                1:       waits = T + $urandom_range(0, 3);
                default: waits = $urandom_range(0, 4);
            endcase
            case (kind)
                0: do_access(1, 0, f3, a, $urandom, $urandom, waits);
                1: do_access(0, 1, f3, a, $urandom, $urandom, waits);
                2: do_access(1, 1, f3, a, $urandom, $urandom, waits);
                default: begin
                    bus.MemAck = 1'($urandom_range(0, 1));
                    step();
                    bus.MemAck = 1'b0;
                end
            endcase
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
